// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit: opcodes, FSM encoding,
// prediction-queue entry layout and default sizing.
package branch_resolve_pkg;

    localparam logic [5:0] OP_BAL = 6'b000001;
    localparam logic [3:0] OP_BS  = 4'b0001;

    localparam int DEPTH_DEF     = 4;
    localparam int FLUSH_CYC_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        predict;
    } pred_entry_t;

    function automatic logic is_branch(input logic [31:0] instr);
        return (instr[31:26] == OP_BAL) || (instr[31:28] == OP_BS);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue. Clear wins over push/pop; a push into a full
// queue is only accepted when a pop frees the head slot in the same cycle.
module pred_fifo
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_clear,
    input  pred_entry_t i_wdata,
    output pred_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    pred_entry_t   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: queues fetch-time predictions, compares them against
// execute-stage outcomes, drives predictor updates and mispredict flushes.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Iadd,
    input  logic [31:0] Idata,
    input  logic        predict,
    input  logic        if_id_write,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        result,
    output logic [31:0] Badd,
    output logic        upd_valid,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] correct_cnt,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt,
    output logic        overflow
);

    localparam logic [2:0] HOLD_LOAD = 3'(FLUSH_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_hold_cnt;

    logic        w_idle;
    logic        w_enq_req;
    logic        w_resolve;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_mispred;
    logic        w_full;
    logic        w_empty;
    pred_entry_t w_head;
    pred_entry_t w_wdata;
    logic [31:0] w_head_pc;
    logic        w_head_pred;

    logic        r_result;
    logic [31:0] r_badd;
    logic        r_upd_valid;
    logic        r_flush;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_correct_cnt;
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;
    logic        r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mispred)         w_state_nxt = ST_HOLD;
            ST_HOLD: if (r_hold_cnt == '0)  w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_enq_req = w_idle && if_id_write && is_branch(Idata);
        w_resolve = w_idle && ex_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_hold_cnt <= '0;
        else if (w_idle && w_mispred)        r_hold_cnt <= HOLD_LOAD;
        else if (!w_idle && r_hold_cnt != 0) r_hold_cnt <= r_hold_cnt - 1'b1;
    end

    // An empty queue stands in as a not-taken prediction for ex_pc.
    assign w_head_pc   = w_empty ? ex_pc : w_head.pc;
    assign w_head_pred = w_empty ? 1'b0  : w_head.predict;
    assign w_mispred   = w_resolve && ((w_head_pc != ex_pc) || (w_head_pred != ex_taken));

    assign w_pop   = w_resolve && !w_empty;
    assign w_push  = w_enq_req && (!w_full || w_pop);
    assign w_drop  = w_enq_req && w_full && !w_pop;
    assign w_wdata = '{pc: Iadd, predict: predict};

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mispred),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result      <= 1'b0;
            r_badd        <= '0;
            r_upd_valid   <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_correct_cnt <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_upd_valid <= w_resolve;
            r_flush     <= w_mispred;
            if (w_resolve) begin
                r_badd   <= ex_pc;
                r_result <= ex_taken;
            end
            if (w_mispred) begin
                r_redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
            if (w_resolve && !w_mispred) r_correct_cnt <= r_correct_cnt + 32'd1;
            if (w_push)                  r_branch_cnt  <= r_branch_cnt + 32'd1;
            if (w_drop)                  r_overflow    <= 1'b1;
        end
    end

    assign result      = r_result;
    assign Badd        = r_badd;
    assign upd_valid   = r_upd_valid;
    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign correct_cnt = r_correct_cnt;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a queue-based reference model
// checked every cycle, plus literal expectations at the key scenario points.
module tb_branch_resolve;

    localparam int TB_DEPTH = 4;
    localparam int TB_FLUSH = 2;
    localparam logic [31:0] W_BAL = 32'h0400_0000;
    localparam logic [31:0] W_BS  = 32'h1000_0000;
    localparam logic [31:0] W_NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Iadd = '0, Idata = '0, ex_pc = '0, ex_target = '0;
    logic        predict = 1'b0, if_id_write = 1'b1, ex_valid = 1'b0, ex_taken = 1'b0;
    logic        result, upd_valid, flush, overflow;
    logic [31:0] Badd, redirect_pc, correct_cnt, branch_cnt, mispred_cnt;

    int checks = 0;
    int failures = 0;

    branch_resolve #(.DEPTH(TB_DEPTH), .FLUSH_CYC(TB_FLUSH)) dut (
        .clk(clk), .rst_n(rst_n), .Iadd(Iadd), .Idata(Idata), .predict(predict),
        .if_id_write(if_id_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target), .result(result), .Badd(Badd),
        .upd_valid(upd_valid), .flush(flush), .redirect_pc(redirect_pc),
        .correct_cnt(correct_cnt), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of outstanding predictions and a count of
    // remaining suppression cycles.
    typedef struct packed { logic [31:0] pc; logic pred; } ent_t;
    ent_t        m_q[$];
    int          m_hold;
    logic        m_upd, m_flush, m_res, m_ovf;
    logic [31:0] m_badd, m_redir, m_corr, m_br, m_mis;

    function automatic logic tb_is_branch(input logic [31:0] w);
        return (w[31:26] == 6'd1) || (w[31:28] == 4'd1);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold = 0;
        m_upd = 0; m_flush = 0; m_res = 0; m_ovf = 0;
        m_badd = 0; m_redir = 0; m_corr = 0; m_br = 0; m_mis = 0;
    endtask

    task automatic model_step();
        ent_t head;
        logic mis;
        m_upd = 0;
        m_flush = 0;
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        mis = 0;
        if (ex_valid) begin
            head = (m_q.size() > 0) ? m_q[0] : '{pc: ex_pc, pred: 1'b0};
            if (m_q.size() > 0) void'(m_q.pop_front());
            mis = (head.pc != ex_pc) || (head.pred != ex_taken);
            m_upd = 1; m_badd = ex_pc; m_res = ex_taken;
            if (mis) begin
                m_flush = 1;
                m_redir = ex_taken ? ex_target : ex_pc + 4;
                m_mis++;
            end else begin
                m_corr++;
            end
        end
        if (if_id_write && tb_is_branch(Idata)) begin
            if (m_q.size() < TB_DEPTH) begin
                m_q.push_back('{pc: Iadd, pred: predict});
                m_br++;
            end else begin
                m_ovf = 1;
            end
        end
        if (mis) begin
            m_q.delete();
            m_hold = TB_FLUSH;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        chk("upd_valid", upd_valid, m_upd);
        chk("flush", flush, m_flush);
        chk("result", result, m_res);
        chk("Badd", Badd, m_badd);
        chk("redirect_pc", redirect_pc, m_redir);
        chk("correct_cnt", correct_cnt, m_corr);
        chk("branch_cnt", branch_cnt, m_br);
        chk("mispred_cnt", mispred_cnt, m_mis);
        chk("overflow", overflow, m_ovf);
    end

    // Inputs change 2 time units after the rising edge, after the model check.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        Idata = W_NOP; Iadd = '0; predict = 0; if_id_write = 1;
        ex_valid = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] w, input logic p);
        Iadd = a; Idata = w; predict = p;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        ex_valid = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_e;
        logic        pr_e;
        idle_in();
        repeat (3) cyc();
        chk("reset_flush", flush, 0);
        chk("reset_badd", Badd, 0);
        rst_n = 1;

        // Correct taken prediction.
        enq(32'h100, W_BAL, 1); cyc(); idle_in();
        chk("s1_branch_cnt", branch_cnt, 1);
        resolve(32'h100, 1, 32'h800); cyc(); idle_in();
        chk("s1_upd", upd_valid, 1);
        chk("s1_badd", Badd, 32'h100);
        chk("s1_result", result, 1);
        chk("s1_flush", flush, 0);
        chk("s1_correct", correct_cnt, 1);
        cyc();
        chk("s1_upd_low", upd_valid, 0);

        // Predicted not-taken, actually taken; HOLD ignores both inputs.
        enq(32'h200, W_BS, 0); cyc(); idle_in();
        resolve(32'h200, 1, 32'h400); cyc(); idle_in();
        chk("s2_flush", flush, 1);
        chk("s2_redirect", redirect_pc, 32'h400);
        chk("s2_mispred", mispred_cnt, 1);
        repeat (TB_FLUSH) begin
            enq(32'h210, W_BAL, 1); resolve(32'h210, 1, 32'h0); cyc();
            chk("s2_hold_upd", upd_valid, 0);
            chk("s2_hold_flush", flush, 0);
        end
        idle_in();
        chk("s2_branch_cnt", branch_cnt, 2);
        cyc();

        // Predicted taken, actually not-taken: fall-through redirect.
        enq(32'h300, W_BAL, 1); cyc(); idle_in();
        resolve(32'h300, 0, 32'h999); cyc(); idle_in();
        chk("s3_redirect", redirect_pc, 32'h304);
        chk("s3_mispred", mispred_cnt, 2);
        repeat (TB_FLUSH + 1) cyc();

        // Stalled fetch does not enqueue.
        enq(32'h310, W_BAL, 1); if_id_write = 0; cyc(); idle_in();
        chk("s4_branch_cnt", branch_cnt, 3);

        // Fill past capacity, then stream push+pop across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            enq(32'h1000 + 4 * i, W_BS, i[0]); cyc();
        end
        idle_in();
        chk("s5_overflow", overflow, 1);
        chk("s5_branch_cnt", branch_cnt, 7);
        for (int j = 0; j < 8; j++) begin
            pc_e = (j < 4) ? 32'h1000 + 4 * j : 32'h2000 + 4 * (j - 4);
            pr_e = (j < 4) ? j[0] : 1'((j - 4) >> 1);
            enq(32'h2000 + 4 * j, W_BAL, j[1]);
            resolve(pc_e, pr_e, 32'h0);
            cyc();
            chk("s5_stream_badd", Badd, pc_e);
            chk("s5_stream_flush", flush, 0);
        end
        idle_in();
        chk("s5_correct", correct_cnt, 9);
        for (int k = 4; k < 8; k++) begin
            resolve(32'h2000 + 4 * k, k[1], 32'h0); cyc();
        end
        idle_in();
        chk("s5_drain_correct", correct_cnt, 13);
        chk("s5_drain_flush", flush, 0);
        resolve(32'h700, 0, 32'h0); cyc(); idle_in();
        chk("s5_empty_nt_correct", correct_cnt, 14);
        resolve(32'h704, 1, 32'h900); cyc(); idle_in();
        chk("s5_empty_tk_flush", flush, 1);
        chk("s5_empty_tk_redirect", redirect_pc, 32'h900);
        repeat (TB_FLUSH) cyc();

        // Address mismatch alone is a mispredict.
        enq(32'h600, W_BS, 0); cyc(); idle_in();
        resolve(32'h604, 0, 32'h0); cyc(); idle_in();
        chk("s6_redirect", redirect_pc, 32'h608);
        chk("s6_mispred", mispred_cnt, 4);

        // Reset asserted inside HOLD.
        rst_n = 0;
        #1;
        chk("s7_rst_flush", flush, 0);
        chk("s7_rst_upd", upd_valid, 0);
        chk("s7_rst_mispred", mispred_cnt, 0);
        chk("s7_rst_redirect", redirect_pc, 0);
        chk("s7_rst_overflow", overflow, 0);
        cyc(); cyc();
        rst_n = 1;
        enq(32'h500, W_BS, 1); cyc(); idle_in();
        resolve(32'h500, 1, 32'h0); cyc(); idle_in();
        chk("s7_upd", upd_valid, 1);
        chk("s7_badd", Badd, 32'h500);
        chk("s7_correct", correct_cnt, 1);
        chk("s7_branch_cnt", branch_cnt, 1);
        chk("s7_flush", flush, 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight prediction entries (power of two, 2..16).
REQ-002 Parameter FLUSH_CYC, default 2, wrong-path suppression cycles after a redirect (1..7).
REQ-003 Ports `clk` (input, 1) and `rst_n` (input, 1) SHALL be the only clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 `Iadd`  input  32  fetch-stage instruction address.
REQ-005 `Idata`  input  32  fetch-stage instruction word.
REQ-006 `predict`  input  1  predictor direction for `Idata`; 1 = taken.
REQ-007 `if_id_write`  input  1  IF/ID advance enable; 0 = pipeline stalled.
REQ-008 `ex_valid`  input  1  a branch resolves in execute this cycle.
REQ-009 `ex_pc`  input  32  address of the resolving branch.
REQ-010 `ex_taken`  input  1  actual outcome of the resolving branch.
REQ-011 `ex_target`  input  32  taken target of the resolving branch.
REQ-012 `result`  output  1  registered actual outcome, sent to the predictor.
REQ-013 `Badd`  output  32  registered address of the branch being updated.
REQ-014 `upd_valid`  output  1  one-cycle predictor-update strobe.
REQ-015 `flush`  output  1  one-cycle pipeline flush strobe.
REQ-016 `redirect_pc`  output  32  correct fetch address, valid while `flush`=1.
REQ-017 `correct_cnt`, `branch_cnt`, `mispred_cnt`  output  32 each  statistics counters.
REQ-018 `overflow`  output  1  sticky flag: enqueue dropped because the queue was full.

Function
REQ-019 A fetched instruction SHALL be a branch when Idata[31:26]==6'b000001 (bal) or Idata[31:28]==4'b0001 (bs).
REQ-020 Enqueue {Iadd, predict} into the FIFO when branch && if_id_write==1 && state==IDLE && not full; `branch_cnt` increments on each enqueue.
REQ-021 Enqueue while full SHALL be dropped and SHALL set `overflow`, which stays set until reset.
REQ-022 When ex_valid==1 in IDLE, pop the head; an empty queue SHALL be treated as a head with predict=0 and pc=ex_pc.
REQ-023 Simultaneous enqueue and pop SHALL both take effect in the same cycle; occupancy is unchanged; wrap-around of the read and write pointers is modulo DEPTH.
REQ-024 Mispredict = (head.pc != ex_pc) || (head.predict != ex_taken).
REQ-025 In cycle N+1 after a resolution in cycle N: upd_valid=1, Badd=ex_pc, result=ex_taken (one cycle of latency).
REQ-026 On a correct resolution, `correct_cnt` increments in cycle N+1.
REQ-027 On a mispredict, in cycle N+1: flush=1, redirect_pc = ex_taken ? ex_target : ex_pc+4, `mispred_cnt` increments, the FIFO is emptied, and the FSM enters HOLD.
REQ-028 The FSM SHALL have states IDLE and HOLD: IDLE→HOLD on a mispredict; HOLD lasts exactly FLUSH_CYC cycles, counted by a 3-bit down-counter, then returns to IDLE.
REQ-029 In HOLD, enqueue and ex_valid SHALL be ignored, with no counter or strobe activity.
REQ-030 Counters SHALL wrap modulo 2^32.
REQ-031 `flush` and `upd_valid` SHALL be low in every cycle without a qualifying event.

Reset
REQ-032 While rst_n==0: FIFO empty, pointers 0, state IDLE, all counters 0, and result, upd_valid, flush, overflow = 0; Badd and redirect_pc = 32'h0.
REQ-033 Reset asserted mid-HOLD or mid-update SHALL abort immediately; the first cycle after deassertion behaves as IDLE with an empty FIFO.

Structure
REQ-034 A shared package SHALL hold the opcodes BAL=6'b000001 and BS=4'b0001, the state encoding (IDLE, HOLD), and the default DEPTH and FLUSH_CYC.
REQ-035 The FIFO SHALL be a sub-module `pred_fifo` with push, pop, clear, full, empty, and head data; branch_resolve contains the FSM, comparison, and counters.

Verification
REQ-036 Enqueue bal at 0x100 with predict=1, then ex_valid with ex_pc=0x100, ex_taken=1 → next cycle: upd_valid=1, Badd=0x100, result=1, flush=0, correct_cnt=1.
REQ-037 Enqueue bs at 0x200 with predict=0, then resolve taken with ex_target=0x400 → flush=1, redirect_pc=0x400, mispred_cnt=1; the next 2 cycles ignore enqueue.
REQ-038 Predict=1, resolve not-taken at ex_pc=0x300 → redirect_pc=0x304.
REQ-039 Five enqueues with DEPTH=4 and no pops → fifth dropped, overflow=1, branch_cnt=4; then simultaneous push/pop for 8 cycles → occupancy stays at 4 and order is preserved across wrap-around.
REQ-040 Branch in Idata with if_id_write=0 → no enqueue, branch_cnt unchanged.
REQ-041 Assert rst_n=0 during HOLD → all outputs at reset values; after release, enqueue at 0x500 resolves correctly.
